// File: rtl/dma_bus_arbiter.sv
// Shared system bus arbiter between the processor and the DMA engine.
// Inserts a dead cycle on every ownership change, tracks the DMA word count,
// and parks long DMA bursts so a waiting processor gets a guaranteed slot.
module dma_bus_arbiter #(
  parameter int unsigned CNTW      = 6,
  parameter int unsigned PWAIT_MAX = 8,
  parameter int unsigned PSLOT     = 4
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            preq,
  input  logic            dreq,
  input  logic [CNTW-1:0] dcount,
  input  logic            dbeat,
  output logic            busybus,
  output logic            grant,
  output logic            pgrant,
  output logic [CNTW:0]   remaining,
  output logic            done,
  output logic            suspended
);

  typedef enum logic [1:0] {PROC, P2D, DMA, D2P} state_t;

  localparam logic [7:0] PWAIT_LIM = 8'(PWAIT_MAX);
  localparam logic [7:0] PSLOT_LIM = 8'(PSLOT);

  state_t        state, state_nxt;
  logic [7:0]    slot_cnt, slot_nxt;
  logic [7:0]    pwait, pwait_nxt, pwait_now;
  logic [CNTW:0] rem_nxt, load_val;
  logic          susp_nxt, done_nxt;

  // Transfer length as loaded on a fresh start; zero encodes 2^CNTW words.
  always_comb begin
    load_val = {1'b0, dcount};
    if (dcount == '0) load_val = {1'b1, {CNTW{1'b0}}};
  end

  // Processor wait count including the current DMA cycle, saturating at the limit,
  // so the PWAIT_MAX-th waiting cycle can already preempt at its beat.
  always_comb begin
    pwait_now = pwait;
    if (preq && (pwait < PWAIT_LIM)) pwait_now = pwait + 8'd1;
  end

  // Next-state, counter and flag logic.
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot_cnt;
    pwait_nxt = '0;
    rem_nxt   = remaining;
    susp_nxt  = suspended;
    done_nxt  = 1'b0;
    case (state)
      PROC: begin
        if (slot_cnt != 8'hFF) slot_nxt = slot_cnt + 8'd1;
        if (suspended) begin
          if (!dreq) begin
            susp_nxt = 1'b0;
            rem_nxt  = '0;
          end else if ((slot_cnt >= PSLOT_LIM) || !preq) begin
            state_nxt = P2D;
            susp_nxt  = 1'b0;
          end
        end else if (dreq && !preq) begin
          state_nxt = P2D;
          rem_nxt   = load_val;
        end
      end
      P2D: state_nxt = DMA;
      DMA: begin
        pwait_nxt = pwait_now;
        if (!dreq) begin
          state_nxt = D2P;
          rem_nxt   = '0;
          susp_nxt  = 1'b0;
        end else if (dbeat) begin
          if (remaining <= 1) begin
            state_nxt = D2P;
            rem_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            rem_nxt = remaining - 1'b1;
            if (pwait_now >= PWAIT_LIM) begin
              state_nxt = D2P;
              susp_nxt  = 1'b1;
            end
          end
        end
        if (state_nxt != DMA) pwait_nxt = '0;
      end
      D2P: begin
        state_nxt = PROC;
        slot_nxt  = '0;
      end
      default: state_nxt = PROC;
    endcase
  end

  // State, counters and registered outputs; outputs follow the next state so
  // busybus flips at the start of each dead cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= PROC;
      slot_cnt  <= '0;
      pwait     <= '0;
      remaining <= '0;
      suspended <= 1'b0;
      done      <= 1'b0;
      busybus   <= 1'b0;
      grant     <= 1'b0;
      pgrant    <= 1'b1;
    end else begin
      state     <= state_nxt;
      slot_cnt  <= slot_nxt;
      pwait     <= pwait_nxt;
      remaining <= rem_nxt;
      suspended <= susp_nxt;
      done      <= done_nxt;
      busybus   <= (state_nxt == P2D) || (state_nxt == DMA);
      grant     <= (state_nxt == DMA);
      pgrant    <= (state_nxt == PROC);
    end
  end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter with default parameters (CNTW=6, PWAIT_MAX=8, PSLOT=4).
module tb_dma_bus_arbiter;

  logic       clock = 1'b0;
  logic       resetn;
  logic       preq, dreq, dbeat;
  logic [5:0] dcount;
  logic       busybus, grant, pgrant, done, suspended;
  logic [6:0] remaining;

  int errors = 0;
  int checks = 0;

  dma_bus_arbiter #(.CNTW(6), .PWAIT_MAX(8), .PSLOT(4)) dut (
    .clock(clock), .resetn(resetn), .preq(preq), .dreq(dreq), .dcount(dcount),
    .dbeat(dbeat), .busybus(busybus), .grant(grant), .pgrant(pgrant),
    .remaining(remaining), .done(done), .suspended(suspended)
  );

  always #5 clock = ~clock;

  // Advance one clock; outputs are sampled and inputs changed 1ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; preq = 1'b0; dreq = 1'b0; dbeat = 1'b0; dcount = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({busybus, grant, pgrant, done, suspended, remaining} !== {5'b00100, 7'd0}) begin
      errors++;
      $display("FAIL reset_hold: got bb/g/pg/done/susp/rem=%b%b%b%b%b/%0d want 00100/0",
               busybus, grant, pgrant, done, suspended, remaining);
    end
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({busybus, grant, pgrant, done, suspended, remaining} !== {5'b00100, 7'd0}) begin
        errors++;
        $display("FAIL idle_%0d: got bb/g/pg/done/susp/rem=%b%b%b%b%b/%0d want 00100/0",
                 i, busybus, grant, pgrant, done, suspended, remaining);
      end
    end
  endtask

  task automatic test_single();
    int g, d;
    logic seen;
    dreq = 1'b1; dcount = 6'd3; dbeat = 1'b1;
    step();
    checks++;
    if ({busybus, grant, pgrant, remaining} !== {3'b100, 7'd3}) begin
      errors++;
      $display("FAIL single_p2d: got bb/g/pg/rem=%b%b%b/%0d want 100/3",
               busybus, grant, pgrant, remaining);
    end
    g = 0; d = 0; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (grant) begin
        checks++;
        if (remaining !== 7'(3 - g)) begin
          errors++;
          $display("FAIL single_rem_%0d: got %0d want %0d", g, remaining, 3 - g);
        end
        g++;
      end
      if (done) begin
        d++; seen = 1'b1; dreq = 1'b0;
        checks++;
        if ({busybus, grant, pgrant, remaining} !== {3'b000, 7'd0}) begin
          errors++;
          $display("FAIL single_d2p: got bb/g/pg/rem=%b%b%b/%0d want 000/0",
                   busybus, grant, pgrant, remaining);
        end
      end
    end
    checks++;
    if (g != 3) begin
      errors++;
      $display("FAIL single_grant_cycles: got %0d want 3", g);
    end
    step();
    checks++;
    if ({pgrant, done, busybus} !== 3'b100) begin
      errors++;
      $display("FAIL single_return: got pg/done/bb=%b%b%b want 100", pgrant, done, busybus);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) d++;
    end
    checks++;
    if (d != 1) begin
      errors++;
      $display("FAIL single_done_count: got %0d want 1", d);
    end
  endtask

  task automatic test_zero_count();
    int g;
    logic seen;
    dreq = 1'b1; dcount = 6'd0; dbeat = 1'b1;
    step();
    checks++;
    if (remaining !== 7'd64) begin
      errors++;
      $display("FAIL zero_load: got %0d want 64", remaining);
    end
    g = 0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      if (grant) g++;
      if (done) begin seen = 1'b1; dreq = 1'b0; end
    end
    checks++;
    if (!seen || g != 64) begin
      errors++;
      $display("FAIL zero_beats: got %0d beats done_seen=%0d want 64 beats done_seen=1", g, seen);
    end
    step();
  endtask

  task automatic test_preempt();
    int g, p, d;
    logic seen;
    logic [6:0] first;
    dcount = 6'd20; dreq = 1'b1; preq = 1'b0; dbeat = 1'b1;
    step();
    preq = 1'b1;
    g = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      checks++;
      if (grant && pgrant) begin
        errors++;
        $display("FAIL preempt_overlap: grant and pgrant both high");
      end
      if (grant) g++;
      else if (suspended) seen = 1'b1;
    end
    checks++;
    if (!seen || g != 8) begin
      errors++;
      $display("FAIL preempt_beats: got %0d beats suspended=%0d want 8 beats suspended=1", g, seen);
    end
    checks++;
    if ({busybus, grant, pgrant, remaining} !== {3'b000, 7'd12}) begin
      errors++;
      $display("FAIL preempt_d2p: got bb/g/pg/rem=%b%b%b/%0d want 000/12",
               busybus, grant, pgrant, remaining);
    end
    dcount = 6'd5;
    p = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (pgrant) p++;
      if (busybus) seen = 1'b1;
    end
    checks++;
    if (!seen || p < 4) begin
      errors++;
      $display("FAIL preempt_slot: got %0d pgrant cycles resumed=%0d want >=4 resumed=1", p, seen);
    end
    checks++;
    if (remaining !== 7'd12) begin
      errors++;
      $display("FAIL preempt_resume_rem: got %0d want 12", remaining);
    end
    preq = 1'b0;
    g = 0; d = 0; seen = 1'b0; first = '0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (grant) begin
        if (g == 0) first = remaining;
        g++;
      end
      if (done) begin d++; seen = 1'b1; dreq = 1'b0; end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) d++;
    end
    checks++;
    if (g != 12 || first !== 7'd12 || d != 1) begin
      errors++;
      $display("FAIL preempt_finish: got beats=%0d first_rem=%0d dones=%0d want 12/12/1", g, first, d);
    end
  endtask

  task automatic test_abort();
    int bad;
    logic seen;
    dcount = 6'd5; dreq = 1'b1; preq = 1'b0; dbeat = 1'b1;
    step();
    step();
    step();
    step();
    checks++;
    if ({grant, remaining} !== {1'b1, 7'd3}) begin
      errors++;
      $display("FAIL abort_pre: got g/rem=%b/%0d want 1/3", grant, remaining);
    end
    dreq = 1'b0;
    step();
    checks++;
    if ({busybus, grant, pgrant, done, suspended, remaining} !== {5'b00000, 7'd0}) begin
      errors++;
      $display("FAIL abort_d2p: got bb/g/pg/done/susp/rem=%b%b%b%b%b/%0d want 00000/0",
               busybus, grant, pgrant, done, suspended, remaining);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (grant || done) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d cycles with grant/done want 0", bad);
    end
    // Abandon a parked transfer by dropping dreq while suspended.
    dcount = 6'd20; dreq = 1'b1; preq = 1'b0;
    step();
    preq = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (suspended) seen = 1'b1;
    end
    dreq = 1'b0;
    step();
    checks++;
    if ({seen, pgrant, suspended} !== 3'b111) begin
      errors++;
      $display("FAIL abandon_parked: got seen/pg/susp=%b%b%b want 111", seen, pgrant, suspended);
    end
    step();
    checks++;
    if ({pgrant, suspended, remaining} !== {2'b10, 7'd0}) begin
      errors++;
      $display("FAIL abandon_clear: got pg/susp/rem=%b%b/%0d want 10/0", pgrant, suspended, remaining);
    end
    preq = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    int d;
    dcount = 6'd10; dreq = 1'b1; preq = 1'b0; dbeat = 1'b1;
    step();
    step();
    checks++;
    if (grant !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: got grant=%b want 1", grant);
    end
    #2;
    resetn = 1'b0; dreq = 1'b0;
    #1;
    checks++;
    if ({busybus, grant, pgrant, remaining} !== {3'b001, 7'd0}) begin
      errors++;
      $display("FAIL areset_now: got bb/g/pg/rem=%b%b%b/%0d want 001/0",
               busybus, grant, pgrant, remaining);
    end
    @(negedge clock);
    resetn = 1'b1;
    d = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done || grant) d++;
    end
    checks++;
    if (d != 0) begin
      errors++;
      $display("FAIL areset_after: got %0d cycles with done/grant want 0", d);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_count();
    test_preempt();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_bus_arbiter.md
# dma_bus_arbiter

Clocked arbiter that owns the shared system bus between the processor and the DMA engine. It generates `busybus` (the select for the P_/D_ bus muxes on IOWrite1/2, memwrite, IOAck1/2 and address), the DMA `grant`, and a processor bus-enable. It also tracks the DMA word count, inserts a dead turnaround cycle on every ownership change, and preempts long DMA bursts so a waiting processor is not starved.

## Interface
Parameters:
- CNTW, 6: width of the DMA word-count field (instruction[5:0]).
- PWAIT_MAX, 8: processor wait cycles tolerated during a DMA burst before preemption; legal range 2..255.
- PSLOT, 4: minimum processor-owned cycles granted after a preemption; legal range 1..255.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- preq  in  1  processor bus request, level.
- dreq  in  1  DMA bus request, level, held high for the whole transfer.
- dcount  in  CNTW  transfer length in words; sampled only on a fresh DMA start; 0 means 2^CNTW.
- dbeat  in  1  DMA completed one bus word this cycle; ignored unless `grant`=1.
- busybus  out  1  mux select: 1 = DMA drives the bus, 0 = processor.
- grant  out  1  DMA may drive the bus this cycle.
- pgrant  out  1  processor may drive the bus this cycle.
- remaining  out  CNTW+1  words left in the current or suspended transfer.
- done  out  1  one-cycle pulse when a transfer completes normally.
- suspended  out  1  a DMA transfer is parked by preemption.

## Operation
- All outputs are registered. State machine states are PROC, P2D, DMA and D2P.
- PROC (reset state): busybus=0, grant=0, pgrant=1.
  - Fresh start: suspended=0, dreq=1 and preq=0 → P2D; load remaining = (dcount==0 ? 2^CNTW : dcount).
  - Processor priority: while preq=1 with suspended=0, stay in PROC.
  - Resume: suspended=1, dreq=1, and either slot counter ≥ PSLOT or preq=0 → P2D; remaining is kept, dcount is not sampled.
  - Abandon: suspended=1 and dreq=0 → clear suspended and remaining, stay in PROC.
  - The slot counter counts cycles in PROC and is cleared on entry to PROC.
- P2D: dead cycle. busybus=1, grant=0, pgrant=0. Always → DMA.
- DMA: busybus=1, grant=1, pgrant=0. Priority order when several conditions hold:
  - dreq=0 (abort) → D2P; remaining=0, suspended=0, no done.
  - dbeat=1 and remaining==1 (complete) → D2P; remaining=0, done pulses in the D2P cycle.
  - dbeat=1 and pwait ≥ PWAIT_MAX (preempt) → D2P; remaining decrements, suspended=1.
  - Otherwise dbeat=1 → remaining decrements, stay in DMA.
- pwait counts cycles in DMA with preq=1. It saturates at PWAIT_MAX, is cleared on leaving DMA, and is held (not cleared) when preq drops.
- Preemption happens only at a word boundary (dbeat=1). A partially transferred word is never cut.
- D2P: dead cycle. busybus=0, grant=0, pgrant=0. Always → PROC.
- Reset asserted mid-transfer: immediate return to PROC with all outputs at reset values. The transfer is lost and no done pulse is issued.
- Reset values: busybus=0, grant=0, pgrant=1, remaining=0, done=0, suspended=0.

## Timing
- Start latency: dreq sampled high in PROC at edge N gives P2D after N and grant=1 after edge N+1.
- A k-word uninterrupted transfer with one dbeat per cycle holds grant for exactly k cycles. Total bus occupancy is k+2 cycles including both dead cycles.
- Ownership changes always pass through exactly one dead cycle with both grants low. grant and pgrant are never 1 in the same cycle.
- busybus switches at the start of the dead cycle, so the mux settles before the new owner drives.
- Preemption: with preq held high from the first DMA cycle and a dbeat every cycle, the earliest D2P is after the beat in the PWAIT_MAX-th DMA cycle. The processor then has pgrant for at least PSLOT cycles while preq stays high.
- done is high for exactly one cycle, coincident with the D2P cycle of completion.
- Wrap-around: dcount=0 transfers 2^CNTW words. remaining never underflows below 0.

## Test plan
- Reset and idle: hold resetn=0, then release with preq=dreq=0 → busybus=0, grant=0, pgrant=1, remaining=0 indefinitely.
- Single transfer: dreq=1, dcount=3, dbeat every granted cycle → grant high 3 cycles starting 2 cycles after the dreq sample; remaining goes 3,2,1,0; done pulses once; pgrant returns after 1 dead cycle.
- Zero count: dcount=0 → remaining loads 64 and exactly 64 beats are accepted before done.
- Preemption (PWAIT_MAX=8, PSLOT=4, dcount=20, preq high throughout):
  - After 8 beats: D2P, suspended=1, remaining=12.
  - pgrant then holds ≥4 cycles.
  - DMA resumes without reloading and completes 12 more beats, with a single done.
- Abort: drop dreq after 2 of 5 beats → D2P, remaining=0, no done, grant never reasserts. Separately, drop dreq while suspended → suspended clears in PROC.
- Async reset mid-DMA: assert resetn=0 between clock edges during grant=1 → grant=0 and busybus=0 immediately without a clock; no done after release.
